// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared entry type and recall-window helpers for the writeback arbiter
`ifndef AL_SIZE
`define AL_SIZE 32
`endif

package wb_arbiter_pkg;

   localparam int AL_SIZE = `AL_SIZE;
   localparam int AL_W    = $clog2(AL_SIZE);
   localparam int DATA_W  = 32;
   localparam int PREG_W  = 7;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [PREG_W-1:0] preg;
      logic              has_dest;
      logic [AL_W-1:0]   al_addr;
      logic              live;
   } wb_entry_t;

   // Distance from the active-list back, so the recall window never wraps.
   function automatic logic [AL_W-1:0] al_rel(input logic [AL_W-1:0] x,
                                              input logic [AL_W-1:0] bk);
      return x - bk;
   endfunction

   function automatic logic al_squashed(input logic [AL_W-1:0] a,
                                        input logic [AL_W-1:0] nf,
                                        input logic [AL_W-1:0] of,
                                        input logic [AL_W-1:0] bk);
      return (al_rel(a, bk) >= al_rel(nf, bk)) && (al_rel(a, bk) < al_rel(of, bk));
   endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// rtl/wb_src_fifo.sv - per-source result FIFO with parallel recall invalidation
module wb_src_fifo
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  wb_entry_t       push_entry,
   input  logic            pop,
   input  logic            recall,
   input  logic [AL_W-1:0] new_front,
   input  logic [AL_W-1:0] old_front,
   input  logic [AL_W-1:0] back,
   output wb_entry_t       head,
   output logic            empty,
   output logic            full
);

   localparam int IDX_W = $clog2(DEPTH);

   wb_entry_t        mem [DEPTH];
   logic [IDX_W:0]   wptr;
   logic [IDX_W:0]   rptr;

   assign empty = (wptr == rptr);
   assign full  = (wptr[IDX_W] != rptr[IDX_W]) && (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]);
   assign head  = mem[rptr[IDX_W-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   // Storage needs no reset: pointers alone define which slots are occupied.
   always_ff @(posedge clk) begin
      if (recall) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (al_squashed(mem[i].al_addr, new_front, old_front, back)) mem[i].live <= 1'b0;
         end
      end
      if (push) mem[wptr[IDX_W-1:0]] <= push_entry;
   end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - buffers functional-unit results and drives up to NUM_WB writeback ports per cycle
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int NUM_SRC = 6,
   parameter int NUM_WB  = 4,
   parameter int DEPTH   = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_SRC-1:0]              i_src_valid,
   output logic [NUM_SRC-1:0]              i_src_ready,
   input  logic [NUM_SRC-1:0][DATA_W-1:0]  i_src_data,
   input  logic [NUM_SRC-1:0][PREG_W-1:0]  i_src_preg,
   input  logic [NUM_SRC-1:0]              i_src_has_dest,
   input  logic [NUM_SRC-1:0][AL_W-1:0]    i_src_al_addr,
   input  logic                            if_recall,
   input  logic [AL_W-1:0]                 new_front,
   input  logic [AL_W-1:0]                 old_front,
   input  logic [AL_W-1:0]                 back,
   output logic [NUM_WB-1:0]               o_wb_valid,
   output logic [NUM_WB-1:0][DATA_W-1:0]   o_wb_data,
   output logic [NUM_WB-1:0][PREG_W-1:0]   o_wb_preg,
   output logic [NUM_WB-1:0]               o_wb_has_dest,
   output logic [NUM_WB-1:0][AL_W-1:0]     o_wb_al_addr,
   output logic                            o_busy
);

   localparam int SRC_W = $clog2(NUM_SRC);

   wb_entry_t          head     [NUM_SRC];
   wb_entry_t          cand_ent [NUM_SRC];
   logic [NUM_SRC-1:0] empty, full, push, pop, cand, head_ok, in_sq, grant;
   logic [SRC_W-1:0]   rr_ptr, rr_next;
   logic [SRC_W-1:0]   port_sel [NUM_WB];
   logic [NUM_WB-1:0]  port_vld;

   assign i_src_ready = ~full;
   assign o_busy      = ~&empty;

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      wb_entry_t in_ent;

      assign in_ent     = '{data: i_src_data[s], preg: i_src_preg[s], has_dest: i_src_has_dest[s],
                            al_addr: i_src_al_addr[s], live: 1'b1};
      assign in_sq[s]   = if_recall && al_squashed(i_src_al_addr[s], new_front, old_front, back);
      assign head_ok[s] = !empty[s] && head[s].live &&
                          !(if_recall && al_squashed(head[s].al_addr, new_front, old_front, back));
      // An empty FIFO lets the incoming result compete directly for a port.
      assign cand[s]     = empty[s] ? (i_src_valid[s] && !in_sq[s]) : head_ok[s];
      assign cand_ent[s] = empty[s] ? in_ent : head[s];
      assign pop[s]      = !empty[s] && (grant[s] || !head_ok[s]);
      assign push[s]     = i_src_valid[s] && !full[s] && !in_sq[s] && !(empty[s] && grant[s]);

      wb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
         .clk        (clk),
         .reset      (reset),
         .push       (push[s]),
         .push_entry (in_ent),
         .pop        (pop[s]),
         .recall     (if_recall),
         .new_front  (new_front),
         .old_front  (old_front),
         .back       (back),
         .head       (head[s]),
         .empty      (empty[s]),
         .full       (full[s])
      );
   end

   always_comb begin : arb
      int n;
      int idx;
      n        = 0;
      idx      = 0;
      grant    = '0;
      port_vld = '0;
      rr_next  = rr_ptr;
      for (int p = 0; p < NUM_WB; p++) port_sel[p] = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_SRC) idx = idx - NUM_SRC;
         if (cand[idx] && n < NUM_WB) begin
            grant[idx]  = 1'b1;
            port_sel[n] = SRC_W'(idx);
            port_vld[n] = 1'b1;
            n           = n + 1;
            rr_next     = (idx == NUM_SRC - 1) ? '0 : SRC_W'(idx + 1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr        <= '0;
         o_wb_valid    <= '0;
         o_wb_data     <= '0;
         o_wb_preg     <= '0;
         o_wb_has_dest <= '0;
         o_wb_al_addr  <= '0;
      end else begin
         rr_ptr     <= rr_next;
         o_wb_valid <= port_vld;
         for (int p = 0; p < NUM_WB; p++) begin
            if (port_vld[p]) begin
               o_wb_data[p]     <= cand_ent[port_sel[p]].data;
               o_wb_preg[p]     <= cand_ent[port_sel[p]].preg;
               o_wb_has_dest[p] <= cand_ent[port_sel[p]].has_dest;
               o_wb_al_addr[p]  <= cand_ent[port_sel[p]].al_addr;
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized self-checking bench for wb_arbiter against a queue-based reference
module tb_wb_arbiter;

   logic             clk = 1'b0;
   logic             reset;
   logic [5:0]       i_src_valid, i_src_ready, i_src_has_dest;
   logic [5:0][31:0] i_src_data;
   logic [5:0][6:0]  i_src_preg;
   logic [5:0][4:0]  i_src_al_addr;
   logic             if_recall;
   logic [4:0]       new_front, old_front, back;
   logic [3:0]       o_wb_valid, o_wb_has_dest;
   logic [3:0][31:0] o_wb_data;
   logic [3:0][6:0]  o_wb_preg;
   logic [3:0][4:0]  o_wb_al_addr;
   logic             o_busy;

   wb_arbiter dut (
      .clk(clk), .reset(reset),
      .i_src_valid(i_src_valid), .i_src_ready(i_src_ready), .i_src_data(i_src_data),
      .i_src_preg(i_src_preg), .i_src_has_dest(i_src_has_dest), .i_src_al_addr(i_src_al_addr),
      .if_recall(if_recall), .new_front(new_front), .old_front(old_front), .back(back),
      .o_wb_valid(o_wb_valid), .o_wb_data(o_wb_data), .o_wb_preg(o_wb_preg),
      .o_wb_has_dest(o_wb_has_dest), .o_wb_al_addr(o_wb_al_addr), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [6:0]  preg;
      logic        hd;
      logic [4:0]  al;
      bit          live;
   } ent_t;

   ent_t        q [6][$];
   int          rr;
   logic [3:0]  exp_valid;
   logic [44:0] exp_pk [4];
   int          seen_al [32];
   int          tests_run, tests_failed;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit tb_sq(input int a);
      int ra, rn, ro;
      ra = (a - int'(back) + 32) % 32;
      rn = (int'(new_front) - int'(back) + 32) % 32;
      ro = (int'(old_front) - int'(back) + 32) % 32;
      return ra >= rn && ra < ro;
   endfunction

   function automatic logic [44:0] pk(input ent_t e);
      return {e.data, e.preg, e.hd, e.al};
   endfunction

   function automatic ent_t in_ent(input int s);
      ent_t e;
      e.data = i_src_data[s]; e.preg = i_src_preg[s]; e.hd = i_src_has_dest[s];
      e.al = i_src_al_addr[s]; e.live = 1'b1;
      return e;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 6; s++) q[s].delete();
      rr = 0;
      exp_valid = '0;
      for (int i = 0; i < 32; i++) seen_al[i] = 0;
   endtask

   // One clock of reference behaviour from current inputs; fills exp_valid/exp_pk for after the edge.
   task automatic model_step();
      bit         cand [6], grant [6], sq_in [6], hok [6];
      ent_t       ce [6];
      logic [5:0] rdy;
      int         n, nrr, s;
      n = 0; nrr = rr;
      for (int i = 0; i < 6; i++) rdy[i] = (q[i].size() < 4);
      chk("ready", i_src_ready, rdy);
      for (int i = 0; i < 6; i++) begin
         grant[i] = 0;
         sq_in[i] = if_recall && tb_sq(i_src_al_addr[i]);
         if (q[i].size() == 0) begin
            hok[i] = 0; cand[i] = i_src_valid[i] && !sq_in[i]; ce[i] = in_ent(i);
         end else begin
            hok[i] = q[i][0].live && !(if_recall && tb_sq(q[i][0].al));
            cand[i] = hok[i]; ce[i] = q[i][0];
         end
      end
      exp_valid = '0;
      for (int k = 0; k < 6; k++) begin
         s = (rr + k) % 6;
         if (cand[s] && n < 4) begin
            grant[s] = 1; exp_pk[n] = pk(ce[s]); exp_valid[n] = 1'b1; n++; nrr = (s + 1) % 6;
         end
      end
      rr = nrr;
      for (int i = 0; i < 6; i++) begin
         bit was_empty;
         was_empty = (q[i].size() == 0);
         if (!was_empty && (grant[i] || !hok[i])) void'(q[i].pop_front());
         if (if_recall) foreach (q[i][j]) if (tb_sq(q[i][j].al)) q[i][j].live = 0;
         if (i_src_valid[i] && rdy[i] && !sq_in[i] && !(was_empty && grant[i])) q[i].push_back(in_ent(i));
      end
   endtask

   task automatic step();
      bit any;
      model_step();
      @(posedge clk); #1;
      chk("wb_valid", o_wb_valid, exp_valid);
      for (int p = 0; p < 4; p++) begin
         if (exp_valid[p]) chk("wb_fields", {o_wb_data[p], o_wb_preg[p], o_wb_has_dest[p], o_wb_al_addr[p]}, exp_pk[p]);
         if (o_wb_valid[p]) seen_al[o_wb_al_addr[p]]++;
      end
      any = 0;
      for (int i = 0; i < 6; i++) if (q[i].size() != 0) any = 1;
      chk("busy", o_busy, any);
   endtask

   task automatic clear_inputs();
      i_src_valid = '0; i_src_data = '0; i_src_preg = '0; i_src_has_dest = '0; i_src_al_addr = '0;
      if_recall = 1'b0;
   endtask

   task automatic set_src(input int s, input logic [31:0] d, input logic [6:0] p, input logic [4:0] al);
      i_src_valid[s] = 1'b1; i_src_data[s] = d; i_src_preg[s] = p;
      i_src_has_dest[s] = 1'b1; i_src_al_addr[s] = al;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      model_reset();
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      int cnt;
      tests_run = 0; tests_failed = 0;
      new_front = '0; old_front = '0; back = '0;
      clear_inputs();
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", o_wb_valid, 4'h0);
      chk("rst_ready", i_src_ready, 6'h3f);
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_data", o_wb_data[0], 32'h0);
      chk("rst_al", o_wb_al_addr[3], 5'h0);
      reset = 1'b0;

      // single result from source 2
      set_src(2, 32'hDEAD, 7'd5, 5'd3);
      step(); clear_inputs();
      chk("single_valid", o_wb_valid, 4'b0001);
      chk("single_data", o_wb_data[0], 32'hDEAD);
      chk("single_preg", o_wb_preg[0], 7'd5);
      chk("single_al", o_wb_al_addr[0], 5'd3);
      step();
      chk("single_busy", o_busy, 1'b0);
      chk("single_idle", o_wb_valid, 4'b0000);

      // oversubscription from rr_ptr = 0
      do_reset();
      for (int s = 0; s < 6; s++) set_src(s, 32'h100 + s, 7'(s), 5'(20 + s));
      step(); clear_inputs();
      chk("over_v1", o_wb_valid, 4'hf);
      for (int p = 0; p < 4; p++) chk("over_p1", o_wb_data[p], 32'h100 + p);
      step();
      chk("over_v2", o_wb_valid, 4'b0011);
      chk("over_p2a", o_wb_data[0], 32'h104);
      chk("over_p2b", o_wb_data[1], 32'h105);
      for (int s = 0; s < 6; s++) set_src(s, 32'h200 + s, 7'(s), 5'(20 + s));
      step(); clear_inputs();
      chk("over_rr0", o_wb_data[0], 32'h200);
      repeat (3) step();

      // recall with back = 0 on queued entries
      do_reset();
      back = 5'd0; new_front = 5'd8; old_front = 5'd14;
      for (int s = 0; s < 6; s++) set_src(s, 32'h300 + s, 7'(s), 5'(20 + s));
      i_src_al_addr[4] = 5'd10; i_src_al_addr[5] = 5'd2;
      step(); clear_inputs();
      for (int s = 0; s < 4; s++) set_src(s, 32'h310 + s, 7'(s), 5'(24 + s));
      i_src_al_addr[3] = 5'd12;
      if_recall = 1'b1;
      step(); clear_inputs();
      repeat (4) step();
      chk("recall_al2", seen_al[2], 1);
      chk("recall_al10", seen_al[10], 0);
      chk("recall_al12", seen_al[12], 0);

      // recall window that wraps past the active-list end
      do_reset();
      back = 5'd28; new_front = 5'd2; old_front = 5'd6;
      for (int s = 0; s < 6; s++) set_src(s, 32'h400 + s, 7'(s), 5'(20 + s));
      i_src_al_addr[4] = 5'd30; i_src_al_addr[5] = 5'd3;
      step(); clear_inputs();
      if_recall = 1'b1;
      step(); clear_inputs();
      repeat (4) step();
      chk("wrap_al30", seen_al[30], 1);
      chk("wrap_al3", seen_al[3], 0);

      // source 1 alone, random gaps
      do_reset();
      for (int c = 0; c < 20; c++) begin
         clear_inputs();
         if ($urandom_range(0, 3) != 0) set_src(1, $urandom, 7'($urandom), 5'($urandom));
         step();
      end
      clear_inputs();
      repeat (3) step();

      // random traffic with oversubscription and occasional recalls
      do_reset();
      for (int c = 0; c < 400; c++) begin
         clear_inputs();
         for (int s = 0; s < 6; s++)
            if ($urandom_range(0, 7) != 0) set_src(s, $urandom, 7'($urandom), 5'($urandom));
         i_src_has_dest = 6'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            if_recall = 1'b1;
            back = 5'($urandom); new_front = 5'($urandom); old_front = 5'($urandom);
         end
         step();
      end
      clear_inputs();
      repeat (10) step();
      chk("drain_busy", o_busy, 1'b0);

      // reset in the middle of a backlog
      do_reset();
      for (int b = 0; b < 2; b++) begin
         for (int s = 0; s < 6; s++) set_src(s, 32'h500 + s, 7'(s), 5'(20 + s));
         step();
      end
      clear_inputs();
      chk("burst_busy", o_busy, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("midrst_valid", o_wb_valid, 4'h0);
      chk("midrst_ready", i_src_ready, 6'h3f);
      chk("midrst_busy", o_busy, 1'b0);
      model_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      cnt = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         cnt += $countones(o_wb_valid);
      end
      chk("midrst_silent", cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
